// File: rtl/spi_slave_regs.sv
// Mode-3 SPI responder with a 64x8 register file, oversampled in the clk domain.
// Define SPI_SLAVE_REGS_AUTOINC_EN to honour the multi-byte (address increment) bit.
module spi_slave_regs #(
   parameter logic [7:0]  DEVID_VAL   = 8'hE5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic       upd_we,
   input  logic [5:0] upd_addr,
   input  logic [7:0] upd_data,
   output logic       reg_wr_stb,
   output logic [5:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES:0]   vld_q;
   logic                   sclk_prev_q;
   logic                   cs_prev_q;

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   logic armed;
   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_sh_q, rx_sh_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic       rd_q, rd_d;
   logic       mb_q, mb_d;
   logic [5:0] addr_q, addr_d;
   logic       miso_q, miso_d;
   logic       miso_oe_q, miso_oe_d;
   logic       stb_q, stb_d;
   logic [5:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;

   logic [7:0] regs_q [64];

   logic [7:0] rx_new;
   logic       mb_cmd;
   logic [5:0] addr_nxt;
   logic [5:0] rd_sel;
   logic [7:0] rd_data;
   logic       spi_we;
   logic [5:0] spi_waddr;
   logic [7:0] spi_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '1;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         vld_q       <= '0;
         sclk_prev_q <= 1'b1;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Edges only count once real input values have filled the chain, so a
   // cs held low across reset release is not mistaken for a new frame.
   assign armed     = vld_q[SYNC_STAGES];
   assign sclk_rise = armed & ~sclk_prev_q & sclk_s;
   assign sclk_fall = armed & sclk_prev_q & ~sclk_s;
   assign cs_rise   = armed & ~cs_prev_q & cs_s;
   assign cs_fall   = armed & cs_prev_q & ~cs_s;

   assign rx_new = {rx_sh_q, mosi_s};

`ifdef SPI_SLAVE_REGS_AUTOINC_EN
   assign mb_cmd = rx_new[6];
`else
   assign mb_cmd = 1'b0;
`endif

   assign addr_nxt = addr_q + {5'd0, mb_q};
   assign rd_sel   = (state_q == CMD) ? rx_new[5:0] : addr_nxt;
   assign rd_data  = (rd_sel == 6'd0) ? DEVID_VAL : regs_q[rd_sel];

   assign spi_waddr = addr_q;
   assign spi_wdata = rx_new;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         rx_sh_q   <= '0;
         tx_sh_q   <= '0;
         rd_q      <= 1'b0;
         mb_q      <= 1'b0;
         addr_q    <= '0;
         miso_q    <= 1'b1;
         miso_oe_q <= 1'b0;
         stb_q     <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_sh_q   <= rx_sh_d;
         tx_sh_q   <= tx_sh_d;
         rd_q      <= rd_d;
         mb_q      <= mb_d;
         addr_q    <= addr_d;
         miso_q    <= miso_d;
         miso_oe_q <= miso_oe_d;
         stb_q     <= stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_sh_d   = rx_sh_q;
      tx_sh_d   = tx_sh_q;
      rd_d      = rd_q;
      mb_d      = mb_q;
      addr_d    = addr_q;
      miso_d    = miso_q;
      miso_oe_d = miso_oe_q;
      stb_d     = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      spi_we    = 1'b0;
      if (cs_rise) begin
         state_d   = IDLE;
         miso_d    = 1'b1;
         miso_oe_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d   = CMD;
                  bit_cnt_d = '0;
                  rx_sh_d   = '0;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  rx_sh_d   = rx_new[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rd_d    = rx_new[7];
                     mb_d    = mb_cmd;
                     addr_d  = rx_new[5:0];
                     state_d = DATA;
                     if (rx_new[7]) begin
                        tx_sh_d   = rd_data;
                        miso_oe_d = 1'b1;
                     end
                  end
               end
            end
            DATA: begin
               if (sclk_rise) begin
                  rx_sh_d   = rx_new[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     addr_d = addr_nxt;
                     if (rd_q) begin
                        tx_sh_d = rd_data;
                     end else if (addr_q != 6'd0) begin
                        spi_we    = 1'b1;
                        stb_d     = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_new;
                     end
                  end
               end else if (sclk_fall && rd_q) begin
                  miso_d  = tx_sh_q[7];
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // SPI write is applied last so it wins an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) regs_q[i] <= '0;
      end else begin
         if (upd_we && upd_addr != 6'd0) regs_q[upd_addr] <= upd_data;
         if (spi_we) regs_q[spi_waddr] <= spi_wdata;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign reg_wr_stb  = stb_q;
   assign reg_wr_addr = wr_addr_q;
   assign reg_wr_data = wr_data_q;
   assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs acting as a mode-3 SPI master.
// Expectations follow SPI_SLAVE_REGS_AUTOINC_EN when it is defined.
module tb_spi_slave_regs;

   localparam int HALF = 4;
   localparam int SYNC = 2;

   logic       clk;
   logic       rst;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic       upd_we;
   logic [5:0] upd_addr;
   logic [7:0] upd_data;
   logic       reg_wr_stb;
   logic [5:0] reg_wr_addr;
   logic [7:0] reg_wr_data;
   logic       busy;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] stb_cnt = 8'd0;
   logic [5:0] last_addr = 6'd0;
   logic [7:0] last_data = 8'd0;

   spi_slave_regs #(
      .DEVID_VAL  (8'hE5),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs         (cs),
      .mosi       (mosi),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .upd_we     (upd_we),
      .upd_addr   (upd_addr),
      .upd_data   (upd_data),
      .reg_wr_stb (reg_wr_stb),
      .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reg_wr_stb) begin
         stb_cnt   <= stb_cnt + 8'd1;
         last_addr <= reg_wr_addr;
         last_data <= reg_wr_data;
      end
   end

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sbit(input logic b, output logic so, output logic oe);
      sclk = 1'b0;
      mosi = b;
      repeat (HALF) @(negedge clk);
      so   = miso;
      oe   = miso_oe;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx,
                       output logic oe_all, output logic oe_any);
      logic so, oe;
      rx     = '0;
      oe_all = 1'b1;
      oe_any = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         sbit(tx[i], so, oe);
         rx[i]  = so;
         oe_all = oe_all & oe;
         oe_any = oe_any | oe;
      end
   endtask

   task automatic cs_lo();
      cs = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_hi();
      cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic upd(input logic [5:0] a, input logic [7:0] d);
      upd_we   = 1'b1;
      upd_addr = a;
      upd_data = d;
      @(negedge clk);
      upd_we   = 1'b0;
   endtask

   task automatic rd_reg(input logic [5:0] a, output logic [7:0] d);
      logic [7:0] c;
      logic       x, y;
      cs_lo();
      xfer({2'b10, a}, c, x, y);
      xfer(8'h00, d, x, y);
      cs_hi();
   endtask

   task automatic wr_reg(input logic [5:0] a, input logic [7:0] d);
      logic [7:0] c;
      logic       x, y;
      cs_lo();
      xfer({2'b00, a}, c, x, y);
      xfer(d, c, x, y);
      cs_hi();
   endtask

   // Local update lands on the exact clk edge that completes the SPI byte.
   task automatic coll(input logic [5:0] sa, input logic [7:0] sd,
                       input logic [5:0] ua, input logic [7:0] ud);
      logic [7:0] c;
      logic       x, y;
      cs_lo();
      xfer({2'b00, sa}, c, x, y);
      for (int i = 7; i >= 1; i--) sbit(sd[i], x, y);
      sclk = 1'b0;
      mosi = sd[0];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (SYNC) @(negedge clk);
      upd_we   = 1'b1;
      upd_addr = ua;
      upd_data = ud;
      @(negedge clk);
      upd_we = 1'b0;
      chk("coll_stb_align", {7'd0, reg_wr_stb}, 8'd1);
      repeat (HALF) @(negedge clk);
      cs_hi();
   endtask

   initial begin
      logic [7:0] d, c, s0;
      logic       oa, oy, x, y;
      rst = 1'b1; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
      upd_we = 1'b0; upd_addr = '0; upd_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_miso", {7'd0, miso}, 8'd1);
      chk("rst_oe", {7'd0, miso_oe}, 8'd0);
      chk("rst_stb", {7'd0, reg_wr_stb}, 8'd0);
      chk("rst_waddr", {2'd0, reg_wr_addr}, 8'd0);
      chk("rst_wdata", reg_wr_data, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      cs_lo();
      chk("busy_hi", {7'd0, busy}, 8'd1);
      xfer(8'h80, c, oa, oy);
      chk("oe_cmd", {7'd0, oy}, 8'd0);
      xfer(8'h00, d, oa, oy);
      chk("devid", d, 8'hE5);
      chk("oe_data", {7'd0, oa}, 8'd1);
      cs_hi();
      chk("oe_end", {7'd0, miso_oe}, 8'd0);
      chk("miso_end", {7'd0, miso}, 8'd1);
      chk("busy_end", {7'd0, busy}, 8'd0);

      s0 = stb_cnt;
      wr_reg(6'h2D, 8'h08);
      chk("wr_stb_cnt", stb_cnt - s0, 8'd1);
      chk("wr_addr", {2'd0, last_addr}, 8'h2D);
      chk("wr_data", last_data, 8'h08);
      rd_reg(6'h2D, d);
      chk("rd_2d", d, 8'h08);

      for (int i = 0; i < 6; i++) upd(6'h32 + 6'(i), 8'h11 * 8'(i + 1));
      cs_lo();
      xfer(8'hF2, c, oa, oy);
      for (int i = 0; i < 6; i++) begin
         xfer(8'h00, d, oa, oy);
`ifdef SPI_SLAVE_REGS_AUTOINC_EN
         chk("burst_rd", d, 8'h11 * 8'(i + 1));
`else
         chk("burst_rd", d, 8'h11);
`endif
      end
      cs_hi();

      s0 = stb_cnt;
      cs_lo();
      xfer(8'h7F, c, oa, oy);
      xfer(8'hAA, c, oa, oy);
      xfer(8'hBB, c, oa, oy);
      cs_hi();
      rd_reg(6'h3F, d);
`ifdef SPI_SLAVE_REGS_AUTOINC_EN
      chk("bw_stb_cnt", stb_cnt - s0, 8'd1);
      chk("bw_3f", d, 8'hAA);
`else
      chk("bw_stb_cnt", stb_cnt - s0, 8'd2);
      chk("bw_3f", d, 8'hBB);
`endif
      rd_reg(6'h00, d);
      chk("bw_00", d, 8'hE5);

      upd(6'h10, 8'h5A);
      s0 = stb_cnt;
      cs_lo();
      xfer(8'h10, c, oa, oy);
      for (int i = 0; i < 5; i++) sbit(1'b1, x, y);
      cs_hi();
      chk("abort_stb", stb_cnt - s0, 8'd0);
      chk("abort_miso", {7'd0, miso}, 8'd1);
      chk("abort_busy", {7'd0, busy}, 8'd0);
      rd_reg(6'h10, d);
      chk("abort_reg", d, 8'h5A);

      cs_lo();
      xfer(8'hB2, c, oa, oy);
      for (int i = 0; i < 3; i++) sbit(1'b0, x, y);
      chk("abrd_oe_mid", {7'd0, miso_oe}, 8'd1);
      chk("abrd_miso_mid", {7'd0, miso}, 8'd0);
      cs_hi();
      chk("abrd_oe_end", {7'd0, miso_oe}, 8'd0);
      chk("abrd_miso_end", {7'd0, miso}, 8'd1);

      coll(6'h20, 8'h99, 6'h20, 8'h55);
      rd_reg(6'h20, d);
      chk("coll_same", d, 8'h99);
      coll(6'h22, 8'h99, 6'h23, 8'h44);
      rd_reg(6'h22, d);
      chk("coll_spi", d, 8'h99);
      rd_reg(6'h23, d);
      chk("coll_upd", d, 8'h44);

      cs_lo();
      xfer(8'h15, c, oa, oy);
      for (int i = 0; i < 3; i++) sbit(1'b1, x, y);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("mrst_busy", {7'd0, busy}, 8'd0);
      chk("mrst_miso", {7'd0, miso}, 8'd1);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("mrst_busy_after", {7'd0, busy}, 8'd1);
      s0 = stb_cnt;
      xfer(8'h77, c, oa, oy);
      xfer(8'h77, c, oa, oy);
      cs_hi();
      chk("mrst_no_stb", stb_cnt - s0, 8'd0);
      rd_reg(6'h32, d);
      chk("mrst_cleared", d, 8'h00);
      rd_reg(6'h37, d);
      chk("mrst_37", d, 8'h00);
      rd_reg(6'h00, d);
      chk("mrst_devid", d, 8'hE5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
